// File: rtl/i2c_slv_pkg.sv
// Shared definitions for the I2C register-write target: FSM encoding,
// R/W bit polarity and the default device address.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    ACK_DEV  = 4'd2,
    ADDR_HI  = 4'd3,
    ACK_HI   = 4'd4,
    ADDR_LO  = 4'd5,
    ACK_LO   = 4'd6,
    DATA     = 4'd7,
    ACK_DATA = 4'd8,
    IGNORE   = 4'd9
  } state_t;

  localparam logic       RW_WRITE     = 1'b0;
  localparam logic [6:0] DEFAULT_SADR = 7'b0010000;

endpackage

// File: rtl/i2c_line_sync.sv
// Pad conditioning for one I2C line: 2-flop synchroniser, FILT_LEN-sample
// glitch filter and single-cycle rise/fall pulses on the filtered level.
module i2c_line_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with level;
  // the level flips only after FILT_LEN of them in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_reg_writer.sv
// I2C target that decodes START, SADR+W, addr_hi, addr_lo, data..., STOP and
// emits one register-write strobe per accepted data byte.
// Build option: define I2C_SLV_AUTOINC_EN to accept further data bytes at address+1.
module i2c_slave_reg_writer
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] SADR     = DEFAULT_SADR,
  parameter int         FILT_LEN = 3,
  parameter int         ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_busy,
  output logic              bus_active,
  output logic              addr_match,
  output logic [3:0]        state_dbg
);

`ifdef I2C_SLV_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
    .clk(clk), .reset(reset), .raw(scl_i),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
    .clk(clk), .reset(reset), .raw(sda_i),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_c, stop_c;
  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [ADDR_W-1:0] shadow;
  logic              byte_rdy;
  logic              data_seen;

  assign state_dbg = state;

  // byte_rdy marks that 8 bits are in shreg; the byte is judged on the
  // following SCL fall so that an ACK is driven during SCL low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      bus_active <= 1'b0;
      addr_match <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      shadow     <= '0;
      byte_rdy   <= 1'b0;
      data_seen  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_c) begin
        state      <= IDLE;
        sda_oe     <= 1'b0;
        bus_active <= 1'b0;
        addr_match <= 1'b0;
        byte_rdy   <= 1'b0;
      end else if (start_c) begin
        state      <= DEV_ADDR;
        sda_oe     <= 1'b0;
        bus_active <= 1'b1;
        addr_match <= 1'b0;
        bit_cnt    <= '0;
        byte_rdy   <= 1'b0;
        data_seen  <= 1'b0;
      end else if (scl_rise) begin
        if (state inside {DEV_ADDR, ADDR_HI, ADDR_LO, DATA}) begin
          shreg   <= {shreg[6:0], sda_lvl};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_rdy <= 1'b1;
        end
      end else if (scl_fall) begin
        if (byte_rdy) begin
          byte_rdy <= 1'b0;
          case (state)
            DEV_ADDR: begin
              if (shreg == {SADR, RW_WRITE}) begin
                state      <= ACK_DEV;
                sda_oe     <= 1'b1;
                addr_match <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
            ADDR_HI: begin
              shadow[15:8] <= shreg;
              state        <= ACK_HI;
              sda_oe       <= 1'b1;
            end
            ADDR_LO: begin
              shadow[7:0] <= shreg;
              state       <= ACK_LO;
              sda_oe      <= 1'b1;
            end
            DATA: begin
              if (wr_busy || (data_seen && !AUTOINC)) begin
                state <= IGNORE;
              end else begin
                state     <= ACK_DATA;
                sda_oe    <= 1'b1;
                wr_valid  <= 1'b1;
                wr_addr   <= data_seen ? wr_addr + 1'b1 : shadow;
                wr_data   <= shreg;
                data_seen <= 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          case (state)
            ACK_DEV:  begin sda_oe <= 1'b0; state <= ADDR_HI; end
            ACK_HI:   begin sda_oe <= 1'b0; state <= ADDR_LO; end
            ACK_LO:   begin sda_oe <= 1'b0; state <= DATA;    end
            ACK_DATA: begin sda_oe <= 1'b0; state <= DATA;    end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg_writer.sv
// Bench for i2c_slave_reg_writer: bit-banged I2C master, frame-level reference
// model and a write scoreboard.
module tb_i2c_slave_reg_writer;
  import i2c_slv_pkg::*;

  localparam logic [6:0] SADR = 7'b0010000;
  localparam int         Q    = 8;
`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        scl_i = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_i;
  logic        wr_busy = 1'b0;
  logic        sda_oe, wr_valid, bus_active, addr_match;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  state_dbg;

  assign sda_i = sda_m & ~sda_oe;

  i2c_slave_reg_writer dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_busy(wr_busy),
    .bus_active(bus_active), .addr_match(addr_match), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int oe_cycles = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (sda_oe) oe_cycles++;
    if (!reset && wr_valid) begin
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_i = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_i = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_i = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    tick(Q);
    sda_m = b; tick(Q);
    scl_i = 1'b1; tick(Q);
    seen = sda_i; tick(Q);
    scl_i = 1'b0;
  endtask

  task automatic recv_ack(output logic ack);
    logic s;
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic [7:0] seen);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], s);
      seen[i] = s;
    end
    recv_ack(ack);
  endtask

  // frame under test
  logic [7:0] fb[8];
  logic       fbusy[8];
  int         flen;

  task automatic load_frame(input int len, input logic [39:0] bytes, input logic busy);
    flen = len;
    for (int k = 0; k < 8; k++) begin
      fb[k]    = (k < 5) ? bytes[39 - 8*k -: 8] : 8'h00;
      fbusy[k] = (k >= 3) ? busy : 1'b0;
    end
  endtask

  // Reference: device byte must be {SADR,W}; two address bytes are always
  // ACKed; data byte n goes to addr+n if the sink is free and (n==0 or
  // auto-increment); the first refusal NACKs that byte and everything after.
  task automatic run_frame();
    logic       exp_ack[8];
    logic       dev_ok, alive, ok, ack;
    logic [7:0] seen;
    logic [15:0] base;
    int         oe0;
    dev_ok = (fb[0] == {SADR, 1'b0});
    alive  = dev_ok;
    base   = {fb[1], fb[2]};
    for (int k = 0; k < flen; k++) begin
      if (k == 0)      exp_ack[k] = dev_ok;
      else if (!alive) exp_ack[k] = 1'b0;
      else if (k < 3)  exp_ack[k] = 1'b1;
      else begin
        ok = !fbusy[k] && (AUTOINC || k == 3);
        exp_ack[k] = ok;
        if (ok) exp_q.push_back({base + 16'(k - 3), fb[k]});
        alive = ok;
      end
    end
    oe0 = oe_cycles;
    i2c_start();
    check("bus_active_start", bus_active, 1);
    for (int k = 0; k < flen; k++) begin
      wr_busy = fbusy[k];
      send_byte(fb[k], ack, seen);
      check($sformatf("ack_b%0d", k), ack, exp_ack[k]);
      check($sformatf("line_b%0d", k), seen, fb[k]);
      if (k == 0) check("addr_match", addr_match, dev_ok);
    end
    wr_busy = 1'b0;
    i2c_stop();
    tick(8);
    check("bus_active_stop", bus_active, 0);
    check("addr_match_stop", addr_match, 0);
    check("writes_drained", exp_q.size(), 0);
    if (!dev_ok) check("oe_quiet", oe_cycles - oe0, 0);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] seen, pat;
    int         r;

    tick(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_bus_active", bus_active, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b0;
    tick(10);

    load_frame(4, 40'h20_12_34_A5_00, 1'b0); run_frame();
    load_frame(4, 40'h22_12_34_A5_00, 1'b0); run_frame();
    load_frame(4, 40'h21_12_34_A5_00, 1'b0); run_frame();
    load_frame(4, 40'h20_00_10_5A_00, 1'b1); run_frame();

    // partial frame cut by a repeated START inside addr_lo
    i2c_start();
    send_byte(8'h20, ack, seen); check("part_ack_dev", ack, 1);
    send_byte(8'h12, ack, seen); check("part_ack_hi", ack, 1);
    pat = 8'h34;
    for (int i = 7; i >= 4; i--) send_bit(pat[i], s);
    load_frame(4, 40'h20_AB_CD_01_00, 1'b0); run_frame();

    load_frame(5, 40'h20_FF_FF_11_22, 1'b0); run_frame();

    // 1-clk SCL glitch in the middle of the device byte
    exp_q.push_back({16'h0001, 8'h77});
    i2c_start();
    pat = 8'h20;
    for (int i = 7; i >= 4; i--) send_bit(pat[i], s);
    tick(2);
    scl_i = 1'b1; tick(1);
    scl_i = 1'b0; tick(10);
    check("glitch_state", state_dbg, DEV_ADDR);
    for (int i = 3; i >= 0; i--) send_bit(pat[i], s);
    recv_ack(ack); check("glitch_ack_dev", ack, 1);
    send_byte(8'h00, ack, seen); check("glitch_ack_hi", ack, 1);
    send_byte(8'h01, ack, seen); check("glitch_ack_lo", ack, 1);
    send_byte(8'h77, ack, seen); check("glitch_ack_data", ack, 1);
    i2c_stop(); tick(8);
    check("glitch_writes", exp_q.size(), 0);

    // reset while the device-address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(pat[i], s);
    tick(Q);
    check("oe_before_reset", sda_oe, 1);
    reset = 1'b1; tick(1);
    check("oe_after_reset", sda_oe, 0);
    check("state_after_reset", state_dbg, IDLE);
    reset = 1'b0;
    i2c_stop(); tick(8);
    check("idle_after_reset", bus_active, 0);

    // randomized frames
    for (int f = 0; f < 16; f++) begin
      r = $urandom_range(0, 3);
      fb[0] = (r < 2) ? {SADR, 1'b0} : (r == 2) ? {SADR, 1'b1} : 8'($urandom_range(0, 255));
      flen = $urandom_range(1, 6);
      for (int k = 1; k < 8; k++) begin
        fb[k]    = 8'($urandom_range(0, 255));
        fbusy[k] = (k >= 3) && ($urandom_range(0, 3) == 0);
      end
      fbusy[0] = 1'b0;
      run_frame();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
